// File: rtl/ps2_key_ctrl.sv
// rtl/ps2_key_ctrl.sv - PS/2 keyboard receiver: sync/filter, 11-bit framing, E0/F0 decode, arrow key state
module ps2_key_ctrl #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 25000
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic [3:0] arrows,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, RECV, CHECK} frame_state_t;
  typedef enum logic [1:0] {D_BASE, D_EXT, D_BRK, D_EXT_BRK} dec_state_t;

  logic [1:0]            clk_sync, data_sync;
  logic [FILTER_LEN-1:0] filt_sr;
  logic                  clk_f, clk_f_d;
  logic                  fe, data_bit;
  frame_state_t          state, state_nxt;
  logic [3:0]            bit_cnt;
  logic [9:0]            shift_reg;
  logic [TW-1:0]         tmo_cnt;
  logic                  timeout, frame_good, byte_ok, err_now;
  dec_state_t            dec_state, dec_nxt;
  logic                  emit, ev_ext, ev_brk;

  // Filtered clock only moves once the whole sample window agrees.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync  <= '1;
      data_sync <= '1;
      filt_sr   <= '1;
      clk_f     <= 1'b1;
      clk_f_d   <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      filt_sr   <= {filt_sr[FILTER_LEN-2:0], clk_sync[1]};
      if (&filt_sr)
        clk_f <= 1'b1;
      else if (~|filt_sr)
        clk_f <= 1'b0;
      clk_f_d   <= clk_f;
    end
  end

  assign fe         = clk_f_d & ~clk_f;
  assign data_bit   = data_sync[1];
  assign frame_good = (^shift_reg[8:0]) & shift_reg[9];
  assign timeout    = (state == RECV) && !fe && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign byte_ok    = (state == CHECK) && frame_good;
  assign err_now    = ((state == CHECK) && !frame_good) || timeout;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fe && !data_bit) state_nxt = RECV;
      RECV: begin
        if (fe && bit_cnt == 4'd9)
          state_nxt = CHECK;
        else if (timeout)
          state_nxt = IDLE;
      end
      CHECK:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bits enter at the top so that after ten shifts {stop, parity, data[7:0]} lines up.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
      tmo_cnt   <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= err_now;
      if (state == RECV) begin
        if (fe) begin
          shift_reg <= {data_bit, shift_reg[9:1]};
          bit_cnt   <= bit_cnt + 4'd1;
          tmo_cnt   <= '0;
        end else begin
          tmo_cnt   <= tmo_cnt + TW'(1);
        end
      end else begin
        bit_cnt <= '0;
        tmo_cnt <= '0;
      end
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n)
      dec_state <= D_BASE;
    else
      dec_state <= dec_nxt;
  end

  assign ev_ext = (dec_state == D_EXT) || (dec_state == D_EXT_BRK);
  assign ev_brk = (dec_state == D_BRK) || (dec_state == D_EXT_BRK);

  always_comb begin
    dec_nxt = dec_state;
    emit    = 1'b0;
    if (err_now) begin
      dec_nxt = D_BASE;
    end else if (byte_ok) begin
      if (shift_reg[7:0] == 8'hE0)
        dec_nxt = D_EXT;
      else if (shift_reg[7:0] == 8'hF0)
        dec_nxt = ev_ext ? D_EXT_BRK : D_BRK;
      else begin
        emit    = 1'b1;
        dec_nxt = D_BASE;
      end
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      key_valid <= 1'b0;
      key_code  <= '0;
      key_ext   <= 1'b0;
      key_break <= 1'b0;
      arrows    <= '0;
    end else begin
      key_valid <= emit;
      if (emit) begin
        key_code  <= shift_reg[7:0];
        key_ext   <= ev_ext;
        key_break <= ev_brk;
        if (ev_ext) begin
          case (shift_reg[7:0])
            8'h75:   arrows[3] <= ~ev_brk;
            8'h72:   arrows[2] <= ~ev_brk;
            8'h6B:   arrows[1] <= ~ev_brk;
            8'h74:   arrows[0] <= ~ev_brk;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// tb/tb_ps2_key_ctrl.sv - scoreboard bench for ps2_key_ctrl
`timescale 1ns/1ps
module tb_ps2_key_ctrl;

  logic       vga_clk  = 1'b0;
  logic       reset_n  = 1'b0;
  logic       ps2_clk  = 1'b1;
  logic       ps2_data = 1'b1;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic [3:0] arrows;
  logic       frame_err;

  ps2_key_ctrl dut (
    .vga_clk   (vga_clk),
    .reset_n   (reset_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ext   (key_ext),
    .key_break (key_break),
    .arrows    (arrows),
    .frame_err (frame_err)
  );

  always #20 vga_clk = ~vga_clk;

  localparam int HALF = 12;
  // raw pin edge -> 2 sync flops, FILTER_LEN window, edge register, then 2-cycle pipeline
  localparam int LAT  = 2 + 4 + 1 + 2;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic [3:0] arr;
  } ev_t;

  ev_t  exp_q[$];
  ev_t  mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_stop_cyc = 0;
  int   err_seen = 0;
  int   err_exp = 0;
  logic prev_valid = 1'b0;
  logic prev_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(posedge vga_clk) cyc++;

  always @(negedge vga_clk) begin
    if (prev_valid) chk("key_valid_pulse", key_valid, 0);
    if (prev_err)   chk("frame_err_pulse", frame_err, 0);
    if (frame_err === 1'b1) err_seen++;
    if (key_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event actual=%0h required=none", key_code);
      end else begin
        mon_e = exp_q.pop_front();
        chk("key_code",  key_code,  mon_e.code);
        chk("key_ext",   key_ext,   mon_e.ext);
        chk("key_break", key_break, mon_e.brk);
        chk("arrows",    arrows,    mon_e.arr);
        chk("latency",   cyc - last_stop_cyc, LAT);
      end
    end
    prev_valid = key_valid;
    prev_err   = frame_err;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge vga_clk);
  endtask

  task automatic send_bit(input logic b, input logic is_stop);
    @(negedge vga_clk);
    ps2_data = b;
    idle(HALF);
    ps2_clk = 1'b0;
    if (is_stop) last_stop_cyc = cyc;
    idle(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits, input logic bad_par);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(fr[i], i == 10);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 11, 1'b0);
    idle(30);
  endtask

  task automatic push(input logic [7:0] code, input logic ext, input logic brk, input logic [3:0] arr);
    ev_t e;
    e.code = code;
    e.ext  = ext;
    e.brk  = brk;
    e.arr  = arr;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge vga_clk);
      n++;
    end
    idle(20);
    chk({name, "_pending"}, exp_q.size(), 0);
    chk({name, "_frame_errs"}, err_seen, err_exp);
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_key_valid"}, key_valid, 0);
    chk({name, "_key_code"},  key_code,  0);
    chk({name, "_key_ext"},   key_ext,   0);
    chk({name, "_key_break"}, key_break, 0);
    chk({name, "_arrows"},    arrows,    0);
    chk({name, "_frame_err"}, frame_err, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(5);
    chk_zero("reset");
    @(negedge vga_clk);
    reset_n = 1'b1;
    idle(20);

    push(8'h75, 1'b1, 1'b0, 4'b1000);
    send_byte(8'hE0);
    send_byte(8'h75);
    drain("ext_make_up");

    push(8'h75, 1'b1, 1'b1, 4'b0000);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    drain("ext_break_up");

    push(8'h75, 1'b0, 1'b0, 4'b0000);
    push(8'h1C, 1'b0, 1'b1, 4'b0000);
    send_byte(8'h75);
    send_byte(8'hF0);
    send_byte(8'h1C);
    drain("plain_keys");

    push(8'h6B, 1'b0, 1'b0, 4'b0000);
    send_byte(8'hE0);
    err_exp++;
    send_bits(8'h6B, 11, 1'b1);
    idle(30);
    send_byte(8'h6B);
    drain("parity_err");

    err_exp++;
    send_bits(8'hA5, 5, 1'b0);
    idle(25100);
    @(negedge vga_clk);
    ps2_data = 1'b0;
    ps2_clk  = 1'b0;
    idle(2);
    ps2_clk  = 1'b1;
    idle(5);
    ps2_data = 1'b1;
    idle(30);
    push(8'h74, 1'b1, 1'b0, 4'b0001);
    send_byte(8'hE0);
    send_byte(8'h74);
    drain("timeout_glitch");

    send_byte(8'hE0);
    send_bits(8'h72, 6, 1'b0);
    @(negedge vga_clk);
    ps2_data = 1'b1;
    idle(4);
    reset_n = 1'b0;
    #1;
    chk_zero("mid_frame_reset");
    idle(10);
    reset_n = 1'b1;
    idle(20);
    push(8'h72, 1'b1, 1'b0, 4'b0100);
    send_byte(8'hE0);
    send_byte(8'h72);
    drain("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
